fifo_write_ctrl: RTL and testbench
==================================

Name: fifo_write_ctrl

Overview:
- Write-side control stage for the async FIFO; sits directly upstream of the write-domain fifo_counter and drives its enable input.
- Accepts data-valid requests over a valid/ready handshake and synchronizes the read-domain gray pointer into the write clock.
- Keeps an extended (wrap-bit) write pointer and derives fill level, full, almost_full and a sticky overflow flag.
- Exports the extended write gray pointer for the read-side synchronizer.

Parameters:
- DEPTH, 8: FIFO entries; power of two, >= 2; must match the fifo_counter DEPTH.
- ALMOST_FULL_LEVEL, DEPTH-2: level at or above which almost_full asserts; range 1..DEPTH.
- SYNC_STAGES, 2: flop stages on the incoming read pointer; >= 2.

Ports:
- clk  in  1  write-domain clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream has a word to write.
- in_ready  out  1  FIFO can accept a word; equals !full.
- write_enable  out  1  in_valid && in_ready; drives fifo_counter enable and the memory write strobe.
- rd_ptr_gray_async  in  $clog2(DEPTH)+1  extended read gray pointer from the read domain; asynchronous to clk.
- wr_ptr_gray  out  $clog2(DEPTH)+1  registered extended write gray pointer.
- level  out  $clog2(DEPTH)+1  words held, as seen in the write domain; range 0..DEPTH.
- full  out  1  level == DEPTH.
- almost_full  out  1  level >= ALMOST_FULL_LEVEL.
- overflow  out  1  sticky: in_valid was high while full.
- clear_overflow  in  1  clears overflow.

Behaviour:
- Notation: AW = $clog2(DEPTH); pointers are AW+1 bits. The MSB is the wrap bit.
- Reset is sampled on the clk rising edge while reset==0. On reset:
  - wr_bin = 0, wr_ptr_gray = 0, every sync stage = 0, overflow = 0.
  - Resulting outputs: level = 0, full = 0, in_ready = 1, almost_full = (ALMOST_FULL_LEVEL==0 ? 1 : 0). The parameter range makes this 0.
- Reset mid-operation discards all pointer state in one edge; the read side must be reset in the same window.
- write_enable is combinational from in_valid and the registered full flag. There is no combinational path from rd_ptr_gray_async to any output.
- Accepted write, at the edge where write_enable==1:
  - wr_bin <= wr_bin + 1, modulo 2^(AW+1); it wraps from 2*DEPTH-1 to 0.
  - wr_ptr_gray <= gray(wr_bin + 1). It is registered, so exactly one bit changes per accepted write.
  - wr_ptr_gray therefore lags write_enable by one cycle.
- Read pointer synchronization:
  - rd_ptr_gray_async passes through SYNC_STAGES flops to give rd_gray_sync.
  - rd_bin_sync = gray-to-binary(rd_gray_sync), computed combinationally.
- Level:
  - level = (wr_bin - rd_bin_sync) modulo 2^(AW+1), computed from registers only.
  - A write raises level on the cycle after acceptance.
  - A read-pointer change is reflected in level SYNC_STAGES cycles after it is stable at the input.
- Full:
  - full = (wr_bin[AW] != rd_bin_sync[AW]) && (wr_bin[AW-1:0] == rd_bin_sync[AW-1:0]), which is equivalent to level == DEPTH.
  - full is pessimistic: it can stay high for up to SYNC_STAGES cycles after a read frees space.
- Empty is not produced here; level == 0 is available.
- Simultaneous write and read-pointer advance: the write is accepted if full was low. level is computed from the new pointers; the net level change is +1-1 = 0 once the sync completes.
- Overflow:
  - Set when in_valid && full at an edge.
  - Cleared when clear_overflow==1 at an edge.
  - If set and clear occur on the same edge, set wins.
  - A rejected write never moves any pointer.
- Write at level DEPTH-1: accepted; full asserts the next cycle. A write attempted in that next cycle is rejected.

Test Plan:
- Reset then idle (DEPTH=8), rd_ptr_gray_async=0 -> level=0, full=0, in_ready=1, almost_full=0, wr_ptr_gray=4'b0000.
- 8 consecutive writes with read held at 0 -> write_enable high for 8 cycles. wr_ptr_gray steps through 0001,0011,0010,0110,0111,0101,0100,1100. almost_full rises when level=6; full=1 and in_ready=0 when level=8. A 9th in_valid is rejected and sets overflow=1.
- From full, drive rd_ptr_gray_async=4'b0001 -> level=7 and full=0 exactly SYNC_STAGES(2) cycles later. The next write is accepted and full returns 1 the following cycle.
- Wrap: 16 writes interleaved with matching read-pointer updates -> wr_bin wraps 15->0. wr_ptr_gray goes 1000->0000, with one bit change per step. level stays within 0..8 and never shows a false full.
- Overflow priority: with overflow=1, assert clear_overflow and in_valid together while full -> overflow stays 1. Clear alone with full=0 -> overflow=0.
- Mid-operation reset at level=5: drive reset=0 for one edge -> level=0, wr_ptr_gray=0, overflow=0, in_ready=1 on the following cycle.

Source files
------------

// File: rtl/fifo_write_ctrl.sv
// Async FIFO write-side control: handshake, extended write pointer,
// read-pointer synchronizer, fill level and full/almost_full/overflow flags.
module fifo_write_ctrl #(
  parameter int DEPTH             = 8,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 2,
  parameter int SYNC_STAGES       = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     write_enable,
  input  logic [$clog2(DEPTH):0]   rd_ptr_gray_async,
  output logic [$clog2(DEPTH):0]   wr_ptr_gray,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     almost_full,
  output logic                     overflow,
  input  logic                     clear_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_LVL = (AW+1)'(ALMOST_FULL_LEVEL);

  logic [AW:0] wr_bin;
  logic [AW:0] wr_bin_next;
  logic [AW:0] rd_gray_sync;
  logic [AW:0] rd_bin_sync;
  logic [AW:0] sync_q [SYNC_STAGES];

  assign wr_bin_next  = wr_bin + (AW+1)'(1);
  assign rd_gray_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_bin      <= '0;
      wr_ptr_gray <= '0;
      overflow    <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rd_ptr_gray_async;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      if (write_enable) begin
        wr_bin      <= wr_bin_next;
        wr_ptr_gray <= wr_bin_next ^ (wr_bin_next >> 1);
      end
      // a set on the same edge as a clear must win
      if (in_valid && full)
        overflow <= 1'b1;
      else if (clear_overflow)
        overflow <= 1'b0;
    end
  end

  always_comb begin
    rd_bin_sync = '0;
    for (int i = 0; i <= AW; i++)
      rd_bin_sync[i] = ^(rd_gray_sync >> i);
  end

  assign level = wr_bin - rd_bin_sync;
  assign full  = (wr_bin[AW] != rd_bin_sync[AW]) &&
                 (wr_bin[AW-1:0] == rd_bin_sync[AW-1:0]);
  assign almost_full  = level >= AF_LVL;
  assign in_ready     = !full;
  assign write_enable = in_valid && !full;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Scoreboard bench for fifo_write_ctrl: counting model of writes/reads,
// expectations queued by the driver and checked by a negedge monitor.
module tb_fifo_write_ctrl;

  localparam int DEPTH = 8;
  localparam int AFL   = DEPTH - 2;
  localparam int SYNC  = 2;
  localparam int AW    = $clog2(DEPTH);
  localparam int MOD   = 2 * DEPTH;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          write_enable;
  logic [AW:0]   rd_ptr_gray_async;
  logic [AW:0]   wr_ptr_gray;
  logic [AW:0]   level;
  logic          full;
  logic          almost_full;
  logic          overflow;
  logic          clear_overflow;

  fifo_write_ctrl #(
    .DEPTH(DEPTH), .ALMOST_FULL_LEVEL(AFL), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .write_enable(write_enable), .rd_ptr_gray_async(rd_ptr_gray_async),
    .wr_ptr_gray(wr_ptr_gray), .level(level), .full(full),
    .almost_full(almost_full), .overflow(overflow),
    .clear_overflow(clear_overflow)
  );

  typedef struct {
    int lvl;
    bit full;
    bit rdy;
    bit we;
    bit af;
    bit ov;
    int wg;
  } exp_t;

  exp_t sb[$];
  int   hist[$];
  int   wr_abs;
  int   rd_abs;
  int   rd_seen;
  bit   ov_m;
  int   n_cmp;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW:0] gray(input int x);
    logic [AW:0] b;
    b = (AW+1)'(x % MOD);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("level", int'(level), e.lvl);
      chk("full", int'(full), int'(e.full));
      chk("in_ready", int'(in_ready), int'(e.rdy));
      chk("write_enable", int'(write_enable), int'(e.we));
      chk("almost_full", int'(almost_full), int'(e.af));
      chk("overflow", int'(overflow), int'(e.ov));
      chk("wr_ptr_gray", int'(wr_ptr_gray), e.wg);
    end
  end

  task automatic step(input bit v, input bit adv, input bit clr,
                      input bit rst);
    exp_t e;
    int   lvl;
    if (rst) rd_abs = 0;
    else if (adv && rd_abs < wr_abs) rd_abs++;
    in_valid          = v;
    clear_overflow    = clr;
    reset             = !rst;
    rd_ptr_gray_async = gray(rd_abs);
    lvl    = wr_abs - rd_seen;
    e.lvl  = lvl;
    e.full = (lvl == DEPTH);
    e.rdy  = !e.full;
    e.we   = v && !e.full;
    e.af   = (lvl >= AFL);
    e.ov   = ov_m;
    e.wg   = int'(gray(wr_abs));
    sb.push_back(e);
    @(posedge clk);
    if (rst) begin
      wr_abs = 0;
      ov_m   = 1'b0;
      hist.delete();
      for (int i = 0; i < SYNC; i++) hist.push_back(0);
    end else begin
      if (e.we) wr_abs++;
      if (v && e.full) ov_m = 1'b1;
      else if (clr) ov_m = 1'b0;
      hist.push_back(rd_abs);
      void'(hist.pop_front());
    end
    rd_seen = hist[0];
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    wr_abs = 0;
    rd_abs = 0;
    rd_seen = 0;
    ov_m = 1'b0;
    for (int i = 0; i < SYNC; i++) hist.push_back(0);
    reset = 1'b0;
    in_valid = 1'b0;
    clear_overflow = 1'b0;
    rd_ptr_gray_async = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(3);
    // fill to full with reads parked, then one rejected write
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    // one read frees a slot after the sync delay
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    // set wins over clear while full, then a lone clear
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    // random traffic wraps both pointers many times
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0), 1'b0);
    // drain, build level 5, then reset in the middle of operation
    while (rd_abs < wr_abs) step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'b0, 1'b0);
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
